axi_lite_copy_master: RTL and testbench

- AXI4-Lite initiator that performs a word-by-word memory copy of `length` 32-bit words from `address_src` to `address_dst`.
- It is the master-side counterpart of the copy register block: it consumes that block's `address_src` / `address_dst` / `length` / `start` outputs and returns `done`.
- It drives the system interconnect with one outstanding transaction at a time.
- Each word is one read (AR/R), then one write (AW/W/B).

---
 rtl/axi_lite_copy_master.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_copy_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_copy_master.sv
// AXI4-Lite initiator copying `length` 32-bit words from address_src to address_dst,
// one read then one write per word, with a single transaction outstanding.
module axi_lite_copy_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   address_src,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   address_dst,
  input  logic [15:0]                     length,
  input  logic                            start,
  output logic                            done,
  output logic                            busy,
  output logic                            error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned LW = 16;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  logic [2:0]    state_q, state_d;
  logic          start_q;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;

  logic          start_edge;
  logic [LW-1:0] cnt_inc;
  logic          aw_done;
  logic          w_done;

  assign start_edge = start & ~start_q;
  assign cnt_inc    = cnt_q + LW'(1);
  assign aw_done    = ~awvalid_q | M_AXI_AWREADY;
  assign w_done     = ~wvalid_q | M_AXI_WREADY;

  // State register plus all datapath and handshake registers
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    done_d    = done_q;
    busy_d    = busy_q;
    error_d   = error_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          src_d   = address_src;
          dst_d   = address_dst;
          len_d   = length;
          cnt_d   = '0;
          error_d = 1'b0;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            done_d    = 1'b0;
            busy_d    = 1'b1;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP == RESP_OKAY) begin
            data_d    = M_AXI_RDATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      // AW and W retire independently; move on once both have completed
      WR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
            src_d = src_q + AW'(4);
            dst_d = dst_q + AW'(4);
            if (cnt_inc == len_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              arvalid_d = 1'b1;
              state_d   = RD_ADDR;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign done          = done_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign M_AXI_ARADDR  = src_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign M_AXI_AWADDR  = dst_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = {SW{1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_axi_lite_copy_master.sv
// Directed bench for axi_lite_copy_master against a behavioural AXI4-Lite memory slave
// with optional random backpressure, AW/W skew and read-error injection.
module tb_axi_lite_copy_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address_src, address_dst;
  logic [15:0] length;
  logic        start;
  logic        done, busy, error;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arprot, awprot;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  // bench controls, written only by the stimulus process
  bit bp;
  bit skew;
  int err_word;

  // slave state, written only by the slave process
  logic [31:0] ar_log[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_strb[$];
  int          hold_bad = 0;
  bit          r_pend, r_hs, b_pend, b_hs, aw_got, w_got;
  int          w_cnt, r_idx;
  logic [31:0] r_addr, aw_c, wd_c;
  logic [3:0]  ws_c;
  bit          ar_wait, aw_wait, w_wait;
  logic [31:0] ar_prev, aw_prev, w_prev;

  always #5 clk = ~clk;

  axi_lite_copy_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .address_src   (address_src),
    .address_dst   (address_dst),
    .length        (length),
    .start         (start),
    .done          (done),
    .busy          (busy),
    .error         (error),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready)
  );

  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  function automatic bit go(input bit en);
    if (!en) return 1'b1;
    return ($urandom_range(0, 2) != 0);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: decides READY/VALID on the falling edge, so handshakes land on the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      r_pend = 1'b0; r_hs = 1'b0; b_pend = 1'b0; b_hs = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; w_cnt = 0;
      ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
    end else begin
      if (ar_wait && !(arvalid && araddr == ar_prev)) hold_bad++;
      if (aw_wait && !(awvalid && awaddr == aw_prev)) hold_bad++;
      if (w_wait && !(wvalid && wdata == w_prev))     hold_bad++;

      if (r_hs) begin rvalid = 1'b0; r_hs = 1'b0; end
      if (b_hs) begin bvalid = 1'b0; b_hs = 1'b0; end

      if (b_pend && !bvalid && go(bp)) begin
        bvalid = 1'b1; bresp = 2'b00; b_pend = 1'b0;
      end
      b_hs = bvalid && bready;

      if (r_pend && !rvalid && go(bp)) begin
        rvalid = 1'b1;
        rdata  = src_word(r_addr);
        rresp  = (r_idx == err_word) ? 2'b10 : 2'b00;
        r_pend = 1'b0;
      end
      r_hs = rvalid && rready;

      arready = arvalid && go(bp);
      if (arvalid && arready) begin
        r_addr = araddr;
        r_idx  = ar_log.size();
        ar_log.push_back(araddr);
        r_pend = 1'b1;
      end

      if (aw_got && !w_got) w_cnt++;
      awready = awvalid && !aw_got && go(bp);
      wready  = wvalid && !w_got && (skew ? (aw_got && w_cnt >= 3) : go(bp));
      if (awvalid && awready) begin aw_got = 1'b1; aw_c = awaddr; end
      if (wvalid && wready)   begin w_got = 1'b1; wd_c = wdata; ws_c = wstrb; end
      if (aw_got && w_got) begin
        wr_addr.push_back(aw_c);
        wr_data.push_back(wd_c);
        wr_strb.push_back(ws_c);
        aw_got = 1'b0; w_got = 1'b0; w_cnt = 0; b_pend = 1'b1;
      end

      ar_wait = arvalid && !arready; ar_prev = araddr;
      aw_wait = awvalid && !awready; aw_prev = awaddr;
      w_wait  = wvalid && !wready;   w_prev  = wdata;
    end
  end

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    address_src = s; address_dst = d; length = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int i = 0;
    while (!done && i < max_cyc) begin
      @(posedge clk); #1;
      i++;
    end
    check_val("done_seen", 64'(done), 64'd1);
  endtask

  task automatic wait_awvalid(input int max_cyc);
    int i = 0;
    while (!awvalid && i < max_cyc) begin
      @(posedge clk); #1;
      i++;
    end
    check_val("awvalid_seen", 64'(awvalid), 64'd1);
  endtask

  task automatic check_writes(input logic [31:0] s, input logic [31:0] d, input int n, input int wb);
    check_val("wr_count", 64'(wr_addr.size() - wb), 64'(n));
    for (int i = 0; i < n && (wb + i) < wr_addr.size(); i++) begin
      check_val("wr_addr", 64'(wr_addr[wb+i]), 64'(d + 32'(4 * i)));
      check_val("wr_data", 64'(wr_data[wb+i]), 64'(src_word(s + 32'(4 * i))));
      check_val("wr_strb", 64'(wr_strb[wb+i]), 64'hF);
    end
  endtask

  int ab, wb;

  initial begin
    rst_n = 1'b0; start = 1'b0; address_src = '0; address_dst = '0; length = '0;
    bp = 1'b0; skew = 1'b0; err_word = -1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, done, busy, error}), 64'd0);
    check_val("rst_araddr", 64'(araddr), 64'd0);
    #2 rst_n = 1'b1;

    // single word, zero-wait, cycle-exact
    wb = wr_addr.size();
    launch(32'h0000_1000, 32'h0000_2000, 16'd1);
    check_val("t1_launch", 64'({arvalid, busy, done}), 64'b110);
    check_val("t1_araddr", 64'(araddr), 64'h1000);
    check_val("t1_prot", 64'({arprot, awprot}), 64'd0);
    @(posedge clk); #1;
    check_val("t1_rd", 64'({arvalid, rready}), 64'b01);
    @(posedge clk); #1;
    check_val("t1_wr", 64'({awvalid, wvalid, wstrb}), 64'h3F);
    check_val("t1_wdata", 64'(wdata), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    check_val("t1_resp", 64'({bready, done}), 64'b10);
    @(posedge clk); #1;
    check_val("t1_done", 64'({done, busy, error}), 64'b100);
    check_writes(32'h0000_1000, 32'h0000_2000, 1, wb);

    // eight words with random backpressure and a stray start edge while busy
    bp = 1'b1;
    ab = ar_log.size(); wb = wr_addr.size();
    launch(32'h0000_5000, 32'h0000_2000, 16'd8);
    repeat (6) @(posedge clk);
    @(negedge clk) start = 1'b1;
    wait_done(600);
    repeat (4) @(posedge clk);
    #1;
    check_val("t2_idle", 64'({busy, done, error}), 64'b010);
    check_val("t2_ar_count", 64'(ar_log.size() - ab), 64'd8);
    for (int i = 0; i < 8 && (ab + i) < ar_log.size(); i++)
      check_val("t2_araddr", 64'(ar_log[ab+i]), 64'(32'h0000_5000 + 32'(4 * i)));
    check_writes(32'h0000_5000, 32'h0000_2000, 8, wb);
    @(negedge clk) start = 1'b0;
    bp = 1'b0;

    // W accepted three cycles after AW
    skew = 1'b1;
    wb = wr_addr.size();
    launch(32'h0000_6000, 32'h0000_7000, 16'd1);
    wait_awvalid(20);
    @(posedge clk); #1;
    check_val("t3_aw_only", 64'({awvalid, wvalid, bready}), 64'b010);
    @(posedge clk); #1;
    check_val("t3_w_hold1", 64'({awvalid, wvalid, bready}), 64'b010);
    @(posedge clk); #1;
    check_val("t3_w_hold2", 64'({awvalid, wvalid, bready}), 64'b010);
    @(posedge clk); #1;
    check_val("t3_w_done", 64'({awvalid, wvalid, bready}), 64'b001);
    wait_done(20);
    check_writes(32'h0000_6000, 32'h0000_7000, 1, wb);
    skew = 1'b0;

    // read error on the third word aborts after two writes
    ab = ar_log.size(); wb = wr_addr.size();
    err_word = ab + 2;
    launch(32'h0000_8000, 32'h0000_9000, 16'd4);
    wait_done(100);
    check_val("t4_status", 64'({done, busy, error}), 64'b101);
    check_val("t4_ar_count", 64'(ar_log.size() - ab), 64'd3);
    check_writes(32'h0000_8000, 32'h0000_9000, 2, wb);
    repeat (3) @(posedge clk);
    #1;
    check_val("t4_no_more_wr", 64'(wr_addr.size() - wb), 64'd2);
    err_word = -1;

    // zero length: done next cycle, error from previous copy cleared, no bus traffic
    ab = ar_log.size();
    launch(32'h0000_A000, 32'h0000_B000, 16'd0);
    check_val("t5_zero", 64'({done, busy, error, arvalid, awvalid, wvalid}), 64'b100000);
    repeat (3) @(posedge clk);
    #1;
    check_val("t5_no_ar", 64'({arvalid, awvalid, wvalid}), 64'd0);
    check_val("t5_ar_count", 64'(ar_log.size() - ab), 64'd0);

    // source pointer wraps past the top of the address space
    ab = ar_log.size(); wb = wr_addr.size();
    launch(32'hFFFF_FFFC, 32'h0000_C000, 16'd2);
    wait_done(40);
    check_val("t6_ar_count", 64'(ar_log.size() - ab), 64'd2);
    if (ar_log.size() - ab >= 2) begin
      check_val("t6_ar0", 64'(ar_log[ab]), 64'hFFFF_FFFC);
      check_val("t6_ar1", 64'(ar_log[ab+1]), 64'h0000_0000);
    end
    check_writes(32'hFFFF_FFFC, 32'h0000_C000, 2, wb);

    // asynchronous reset while AWVALID is high, then a clean copy
    launch(32'h0000_3000, 32'h0000_4000, 16'd3);
    wait_awvalid(20);
    #2 rst_n = 1'b0;
    #1;
    check_val("t7_rst_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, done, busy, error}), 64'd0);
    check_val("t7_rst_araddr", 64'(araddr), 64'd0);
    check_val("t7_rst_awaddr", 64'(awaddr), 64'd0);
    check_val("t7_rst_wdata", 64'(wdata), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wb = wr_addr.size();
    launch(32'h0000_3000, 32'h0000_4000, 16'd3);
    wait_done(60);
    check_val("t7_status", 64'({done, busy, error}), 64'b100);
    check_writes(32'h0000_3000, 32'h0000_4000, 3, wb);

    check_val("axi_hold", 64'(hold_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
